// File: rtl/fifo_pkt_reader_pkg.sv
// Shared packet-reader definitions: FSM state encoding and the header
// length-field extraction used by both the header writer and this reader.
package fifo_pkt_reader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } rd_state_t;

  // Works on a 64-bit view of the header so one helper serves any field placement.
  function automatic logic [63:0] hdr_len_field(input logic [63:0] word,
                                                input int unsigned lsb,
                                                input int unsigned width);
    logic [63:0] mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (word >> lsb) & mask;
  endfunction

endpackage

// File: rtl/pkt_skid_buf.sv
// Two-entry output buffer, head registered onto the outputs; one-cycle push-to-head
// latency when empty; accepts a push while full only if the head pops that cycle.
module pkt_skid_buf #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         head_vld,
  output logic [W-1:0] head_dat,
  output logic [1:0]   count
);

  logic [W-1:0] e0, e1;
  logic [1:0]   cnt;
  logic         do_pop, do_push;

  assign do_pop  = pop & (cnt != 2'd0);
  assign do_push = push & ((cnt != 2'd2) | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else if (clr) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_dat;
          else             e1 <= push_dat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever stays.
          if (cnt == 2'd2) begin
            e0 <= e1;
            e1 <= push_dat;
          end else begin
            e0 <= push_dat;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_vld = (cnt != 2'd0);
  assign head_dat = e0;
  assign count    = cnt;

endmodule

// File: rtl/fifo_pkt_reader.sv
// Drains the cell FIFO into sop/eop-framed packets, dropping oversized ones; a word
// popped at edge N is valid after N; stops popping once two words are held unaccepted.
module fifo_pkt_reader
  import fifo_pkt_reader_pkg::*;
#(
  parameter int DBITWIDTH = 32,
  parameter int LEN_LSB   = 0,
  parameter int LEN_WIDTH = 8,
  parameter int MAX_LEN   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  input  logic [DBITWIDTH-1:0] fifo_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DBITWIDTH-1:0] out_data,
  output logic                 out_sop,
  output logic                 out_eop,
  output logic                 err_oversize,
  output logic [15:0]          pkt_count,
  output logic [15:0]          drop_count
);

  localparam int BW = DBITWIDTH + 2;
  localparam logic [LEN_WIDTH-1:0] MAX_LEN_W = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0] ONE_W     = LEN_WIDTH'(1);

  rd_state_t            state;
  logic [LEN_WIDTH-1:0] remaining;
  logic [LEN_WIDTH-1:0] hdr_len;
  logic [1:0]           buf_cnt;
  logic [BW-1:0]        buf_head;
  logic [BW-1:0]        push_dat;
  logic                 push, pop, hdr_ok, is_eop, out_fire;

  assign hdr_len = LEN_WIDTH'(hdr_len_field(64'(fifo_data), LEN_LSB, LEN_WIDTH));
  assign hdr_ok  = (hdr_len <= MAX_LEN_W);

  // Pop decision looks only at buffer occupancy, never at out_ready.
  assign fifo_read = rst_n & ~clr & ~fifo_empty & ((state == DROP) | (buf_cnt != 2'd2));

  assign push     = fifo_read & (((state == IDLE) & hdr_ok) | (state == PAYLOAD));
  assign is_eop   = (state == IDLE) ? (hdr_len == '0) : (remaining == ONE_W);
  assign push_dat = {fifo_data, (state == IDLE), is_eop};
  assign pop      = out_valid & out_ready;
  assign out_fire = pop & out_eop;

  pkt_skid_buf #(.W(BW)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_vld (out_valid),
    .head_dat (buf_head),
    .count    (buf_cnt)
  );

  assign {out_data, out_sop, out_eop} = buf_head;

  // Counters are port statistics and survive clr; only rst_n zeroes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      remaining    <= '0;
      err_oversize <= 1'b0;
      pkt_count    <= 16'd0;
      drop_count   <= 16'd0;
    end else if (clr) begin
      state        <= IDLE;
      remaining    <= '0;
      err_oversize <= 1'b0;
    end else begin
      err_oversize <= 1'b0;
      if (out_fire && pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
      if (fifo_read) begin
        case (state)
          IDLE: begin
            if (!hdr_ok) begin
              state        <= DROP;
              remaining    <= hdr_len;
              err_oversize <= 1'b1;
              if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end else if (hdr_len != '0) begin
              state     <= PAYLOAD;
              remaining <= hdr_len;
            end
          end
          PAYLOAD, DROP: begin
            remaining <= remaining - ONE_W;
            if (remaining == ONE_W) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader: models the upstream FIFO, captures
// accepted beats and compares them with hand-built expected packets.
module tb_fifo_pkt_reader;

  localparam int MAXL = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        fifo_empty, fifo_read;
  logic [31:0] fifo_data, out_data;
  logic        out_valid, out_sop, out_eop, err_oversize;
  logic        out_ready = 1'b0;
  logic [15:0] pkt_count, drop_count;

  always #5 clk = ~clk;

  fifo_pkt_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .fifo_empty   (fifo_empty),
    .fifo_read    (fifo_read),
    .fifo_data    (fifo_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .err_oversize (err_oversize),
    .pkt_count    (pkt_count),
    .drop_count   (drop_count)
  );

  // Upstream show-ahead FIFO model; shares clr with the reader.
  logic [31:0] fmem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        empty_force = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr) | empty_force;
  assign fifo_data  = fmem[rd_ptr[9:0]];

  always @(posedge clk) begin
    if (clr)            rd_ptr <= wr_ptr;
    else if (fifo_read) rd_ptr <= rd_ptr + 1;
  end

  // Output monitor, sampled on the falling edge.
  logic [31:0] cap_dat [0:255];
  bit          cap_sop [0:255];
  bit          cap_eop [0:255];
  int          cap_cyc [0:255];
  int          pop_cyc [0:1023];
  int          cap_n = 0, cyc = 0, viol = 0, err_cnt = 0, stab_err = 0;
  bit          prev_stall = 1'b0;
  logic [33:0] prev_word = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (fifo_read) begin
      pop_cyc[rd_ptr[9:0]] = cyc;
      if (fifo_empty) viol = viol + 1;
    end
    if (err_oversize) err_cnt = err_cnt + 1;
    if (rst_n && !clr) begin
      if (prev_stall && (!out_valid || {out_data, out_sop, out_eop} != prev_word))
        stab_err = stab_err + 1;
      if (out_valid && out_ready && cap_n < 256) begin
        cap_dat[cap_n] = out_data;
        cap_sop[cap_n] = out_sop;
        cap_eop[cap_n] = out_eop;
        cap_cyc[cap_n] = cyc;
        cap_n = cap_n + 1;
      end
    end
    prev_stall = rst_n && !clr && out_valid && !out_ready;
    prev_word  = {out_data, out_sop, out_eop};
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_dat [0:255];
  bit          exp_sop [0:255];
  bit          exp_eop [0:255];
  int          exp_n = 0, cmp_idx = 0;

  function automatic logic [31:0] hdr(input int id, input int len);
    return {16'hCAFE, 8'(id), 8'(len)};
  endfunction

  function automatic logic [31:0] pay(input int id, input int i);
    return {8'(id), 16'h5A5A, 8'(i)};
  endfunction

  task automatic load(input logic [31:0] w);
    fmem[wr_ptr[9:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic add_exp(input logic [31:0] d, input bit s, input bit e);
    exp_dat[exp_n] = d;
    exp_sop[exp_n] = s;
    exp_eop[exp_n] = e;
    exp_n = exp_n + 1;
  endtask

  task automatic send_pkt(input int id, input int len);
    bit keep;
    keep = (len <= MAXL);
    load(hdr(id, len));
    if (keep) add_exp(hdr(id, len), 1'b1, len == 0);
    for (int i = 1; i <= len; i++) begin
      load(pay(id, i));
      if (keep) add_exp(pay(id, i), 1'b0, i == len);
    end
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (cap_n < exp_n && k < 500) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    chk({tag, "_beats"}, cap_n, exp_n);
    for (int i = cmp_idx; i < exp_n && i < cap_n; i++) begin
      chk($sformatf("%s_dat%0d", tag, i), cap_dat[i], exp_dat[i]);
      chk($sformatf("%s_sop%0d", tag, i), cap_sop[i], exp_sop[i]);
      chk($sformatf("%s_eop%0d", tag, i), cap_eop[i], exp_eop[i]);
    end
    cmp_idx = exp_n;
  endtask

  initial begin
    int base, h0, err0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_sop", out_sop, 0);
    chk("rst_eop", out_eop, 0);
    chk("rst_data", out_data, 0);
    chk("rst_err", err_oversize, 0);
    chk("rst_read", fifo_read, 0);
    chk("rst_pkt", pkt_count, 0);
    chk("rst_drop", drop_count, 0);

    // len=3 packet, continuous ready: latency 1 and back-to-back beats
    @(posedge clk); #1;
    out_ready = 1'b1;
    base = exp_n;
    h0   = wr_ptr;
    send_pkt(1, 3);
    drain("t1");
    chk("t1_latency", cap_cyc[base] - pop_cyc[h0], 1);
    chk("t1_b2b", cap_cyc[base + 3] - cap_cyc[base], 3);
    chk("t1_pkt", pkt_count, 1);

    // zero-length packet
    @(posedge clk); #1;
    send_pkt(2, 0);
    drain("t2");
    chk("t2_pkt", pkt_count, 2);

    // oversized packet dropped, following packet intact
    @(posedge clk); #1;
    err0 = err_cnt;
    send_pkt(3, MAXL + 1);
    send_pkt(4, 1);
    drain("t3");
    chk("t3_err_pulses", err_cnt - err0, 1);
    chk("t3_drop", drop_count, 1);
    chk("t3_pkt", pkt_count, 3);

    // backpressure mid-packet
    @(posedge clk); #1;
    load(hdr(5, 4)); add_exp(hdr(5, 4), 1'b1, 1'b0);
    load(pay(5, 1)); add_exp(pay(5, 1), 1'b0, 1'b0);
    drain("t4a");
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      load(pay(5, i));
      add_exp(pay(5, i), 1'b0, i == 4);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t4_read_full", fifo_read, 0);
    chk("t4_left_in_fifo", wr_ptr - rd_ptr, 1);
    chk("t4_valid", out_valid, 1);
    chk("t4_head", out_data, pay(5, 2));
    chk("t4_no_beats", cap_n, cmp_idx);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("t4b");
    chk("t4_stable", stab_err, 0);
    chk("t4_pkt", pkt_count, 4);

    // FIFO empty flag toggling within a len=2 packet
    @(posedge clk); #1;
    empty_force = 1'b1;
    send_pkt(6, 2);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      empty_force = ~empty_force;
    end
    empty_force = 1'b0;
    drain("t5");
    chk("t5_read_on_empty", viol, 0);
    chk("t5_pkt", pkt_count, 5);

    // clr mid-packet
    @(posedge clk); #1;
    out_ready = 1'b0;
    load(hdr(7, 4));
    load(pay(7, 1));
    load(pay(7, 2));
    repeat (4) @(posedge clk);
    #1;
    clr = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t6_read_in_clr", fifo_read, 0);
    @(posedge clk); #1;
    clr = 1'b0;
    @(negedge clk);
    chk("t6_valid_after_clr", out_valid, 0);
    chk("t6_pkt_kept", pkt_count, 5);
    chk("t6_drop_kept", drop_count, 1);
    chk("t6_no_beats", cap_n, exp_n);
    @(posedge clk); #1;
    send_pkt(8, 1);
    drain("t6");
    chk("t6_pkt", pkt_count, 6);
    chk("end_err_total", err_cnt, 1);
    chk("end_read_on_empty", viol, 0);
    chk("end_stable", stab_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
